button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Conditions raw push-button inputs before the button PIO's edge-capture/IRQ logic.
//   Per channel:
//   - 2-FF synchronisation.
//   - Polarity normalisation, so 1 = pressed.
//   - Counter-based debounce, producing a clean level.
//   - One-cycle press and release strobes.
//   btn_level drives the PIO in_port directly, so each bounce no longer raises a separate edge IRQ.
// PARAMETERS
//   WIDTH            2       number of button channels
//   DEBOUNCE_CYCLES  500000  consecutive stable cycles needed to accept a change (10 ms @ 50 MHz); legal range >=1
//   ACTIVE_LOW       1       1: raw pin low = pressed; 0: raw pin high = pressed
// PORTS
//   clk          in   1      system clock; single clock domain
//   reset        in   1      synchronous, active-high reset
//   btn_raw      in   WIDTH  asynchronous raw button pins
//   btn_level    out  WIDTH  debounced level, 1 = pressed; connects to PIO in_port
//   btn_press    out  WIDTH  1-cycle strobe when btn_level rises
//   btn_release  out  WIDTH  1-cycle strobe when btn_level falls
// BEHAVIOUR
//   Reset (sampled on rising clk while reset=1):
//   - sync stages load the released value (ACTIVE_LOW ? 1 : 0).
//   - counters = 0; btn_level = 0; btn_press = 0; btn_release = 0.
//   - Reset wins over every other event in that cycle.
//   Synchroniser: s1 <= btn_raw; s2 <= s1. cand = ACTIVE_LOW ? ~s2 : s2.
//   Per channel i (all channels fully independent, no shared state):
//   - cand[i] == btn_level[i]: cnt[i] <= 0 (any agreement restarts the count).
//   - cand[i] != btn_level[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
//   - cand[i] != btn_level[i] and cnt[i] == DEBOUNCE_CYCLES-1:
//     btn_level[i] <= cand[i]; cnt[i] <= 0;
//     btn_press[i] <= cand[i]; btn_release[i] <= ~cand[i].
//   - Strobes otherwise 0; all outputs registered; a strobe is never longer than 1 cycle.
//   Counter width: $clog2(DEBOUNCE_CYCLES+1); cnt never exceeds DEBOUNCE_CYCLES-1, no wrap.
//   Latency:
//   - A clean raw transition held steady updates btn_level and the strobe exactly DEBOUNCE_CYCLES+2 rising edges later (2 sync + N stable).
//   - DEBOUNCE_CYCLES=1: latency 3 edges, no filtering beyond the synchroniser.
//   Glitch rejection: disagreement lasting <DEBOUNCE_CYCLES cycles at s2 never changes btn_level.
//   Bounce: each return to agreement clears cnt; acceptance is timed from the last transition.
//   Simultaneous events on different channels: press/release strobes may coincide in one cycle.
//   Reset mid-count: partial count is discarded.
//   - After deassert, a button still held pressed is accepted DEBOUNCE_CYCLES+2 edges later, with a press strobe.
// TESTING (DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, WIDTH=2)
//   1 Reset with btn_raw=2'b11, hold 20 cycles -> btn_level=00; btn_press=btn_release=00 throughout.
//   2 btn_raw[0] 1->0 at edge T, held -> btn_level[0]=1 and btn_press[0] high for one cycle only at edge T+10; ch1 stays 0.
//   3 btn_raw[0] toggles every 3 cycles for 30 cycles, then held 0 -> exactly one btn_press[0], 10 edges after final toggle.
//   4 btn_raw[1] low for 7 cycles then high -> btn_level[1], btn_press[1], btn_release[1] never assert.
//   5 ch1 pressed (level=1), then ch0 falls and ch1 rises at the same edge -> btn_press[0] and btn_release[1] in the same cycle.
//   6 Hold btn_raw[0]=0; assert reset 1 cycle at 5 cycles into count -> level 0, no strobe; press strobe 10 edges after reset deassert.

Source files
------------

// File: rtl/button_debouncer.sv
// Per-channel push-button conditioner: 2-FF synchroniser, polarity normalisation,
// counter-based debounce and single-cycle press/release strobes.
module button_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RELEASED_RAW = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] cand;

  // Synchroniser resets to the idle pin level so no phantom press follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg <= RELEASED_RAW;
      s2_reg <= RELEASED_RAW;
    end else begin
      s1_reg <= btn_raw;
      s2_reg <= s1_reg;
    end
  end

  assign cand = ACTIVE_LOW ? ~s2_reg : s2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             level_reg;
      logic             level_next;
      logic             press_reg;
      logic             press_next;
      logic             release_reg;
      logic             release_next;

      // Any sample agreeing with the current level restarts the stability count.
      always_comb begin
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (cand[gi] == level_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          level_next   = cand[gi];
          press_next   = cand[gi];
          release_next = ~cand[gi];
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          cnt_reg     <= cnt_next;
          level_reg   <= level_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus randomised bouncing,
// every cycle compared against a sliding-window reference model.
module tb_button_debouncer;

  localparam int N = 8;

  logic       clk;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int n_checks = 0;
  int n_err    = 0;

  button_debouncer #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(N),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pressed-ness values in flight through the synchroniser,
  // and the history of pressed-ness seen at the filter since the last reset.
  logic [1:0] pipe_q[$];
  logic [1:0] hist_q[$];
  logic [1:0] m_level;
  logic [1:0] m_press;
  logic [1:0] m_release;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A level flips when the last N filter samples all disagree with it.
  task automatic model_edge(input logic rst, input logic [1:0] raw);
    logic [1:0] c;
    bit         all_diff;
    m_press   = 2'b00;
    m_release = 2'b00;
    if (rst) begin
      m_level = 2'b00;
      pipe_q.delete();
      pipe_q.push_back(2'b00);
      pipe_q.push_back(2'b00);
      hist_q.delete();
    end else begin
      c = pipe_q.pop_front();
      pipe_q.push_back(~raw);
      hist_q.push_back(c);
      if (hist_q.size() > 4 * N) void'(hist_q.pop_front());
      for (int ch = 0; ch < 2; ch++) begin
        all_diff = (hist_q.size() >= N);
        for (int j = 0; j < N && all_diff; j++)
          if (hist_q[hist_q.size() - 1 - j][ch] == m_level[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[ch]   = c[ch];
          m_press[ch]   = c[ch];
          m_release[ch] = ~c[ch];
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] raw);
    reset   = rst;
    btn_raw = raw;
    @(posedge clk);
    model_edge(rst, raw);
    #1;
    check("level", int'(btn_level), int'(m_level));
    check("press", int'(btn_press), int'(m_press));
    check("release", int'(btn_release), int'(m_release));
  endtask

  task automatic hold(input logic [1:0] raw, input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, raw);
  endtask

  int first_hit;
  int n_hit;
  int n_bad;
  int hold_cnt[2];
  logic [1:0] rnd_raw;

  initial begin
    reset   = 1'b1;
    btn_raw = 2'b11;

    // 1: reset held with buttons released
    n_bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 2'b11);
      if (btn_press != 2'b00 || btn_release != 2'b00) n_bad++;
    end
    check("s1_level", int'(btn_level), 0);
    check("s1_strobes", n_bad, 0);
    $display("scenario 1: reset hold, level=%b", btn_level);

    // 2: clean press on ch0
    first_hit = -1; n_hit = 0; n_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 2'b10);
      if (btn_press[0]) begin
        n_hit++;
        if (first_hit < 0) first_hit = k;
      end
      if (btn_level[1] || btn_press[1]) n_bad++;
    end
    check("s2_press_edge", first_hit, 10);
    check("s2_press_count", n_hit, 1);
    check("s2_ch1_quiet", n_bad, 0);
    check("s2_level0", int'(btn_level[0]), 1);
    $display("scenario 2: clean press, strobe at edge %0d", first_hit);
    hold(2'b11, 12);

    // 3: bouncing ch0 then held pressed
    n_hit = 0; first_hit = -1;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, {1'b1, (((i / 3) % 2) == 0) ? 1'b0 : 1'b1});
      if (btn_press[0]) n_hit++;
    end
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 2'b10);
      if (btn_press[0]) begin
        n_hit++;
        if (first_hit < 0) first_hit = k;
      end
    end
    check("s3_press_edge", first_hit, 10);
    check("s3_press_count", n_hit, 1);
    $display("scenario 3: bounce, %0d press strobe(s), last at edge %0d", n_hit, first_hit);
    hold(2'b11, 12);

    // 4: short glitch on ch1 is rejected
    n_bad = 0;
    for (int k = 0; k < 19; k++) begin
      step(1'b0, (k < 7) ? 2'b01 : 2'b11);
      if (btn_level[1] || btn_press[1] || btn_release[1]) n_bad++;
    end
    check("s4_glitch", n_bad, 0);
    $display("scenario 4: 7-cycle glitch, %0d ch1 assertions", n_bad);

    // 5: ch0 press and ch1 release land together
    hold(2'b01, 12);
    check("s5_ch1_held", int'(btn_level), 2);
    first_hit = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 2'b10);
      if (btn_press[0] && btn_release[1] && first_hit < 0) first_hit = k;
    end
    check("s5_coincident_edge", first_hit, 10);
    $display("scenario 5: coincident strobes at edge %0d", first_hit);
    hold(2'b11, 12);

    // 6: reset mid-count discards the partial count
    hold(2'b10, 5);
    step(1'b1, 2'b10);
    check("s6_rst_level", int'(btn_level), 0);
    check("s6_rst_press", int'(btn_press), 0);
    first_hit = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 2'b10);
      if (btn_press[0] && first_hit < 0) first_hit = k;
    end
    check("s6_press_edge", first_hit, 10);
    $display("scenario 6: reset mid-count, press at edge %0d after deassert", first_hit);
    hold(2'b11, 12);

    // Random bouncing with occasional resets, checked every cycle by the model
    rnd_raw = 2'b11;
    hold_cnt[0] = 0;
    hold_cnt[1] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold_cnt[ch] == 0) begin
          rnd_raw[ch]  = ~rnd_raw[ch];
          hold_cnt[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 30) : $urandom_range(1, 10);
        end
        hold_cnt[ch]--;
      end
      step(($urandom_range(0, 499) == 0), rnd_raw);
    end
    $display("random phase: 3000 cycles, level=%b", btn_level);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
